// File: rtl/parking_gate_ctrl_pkg.sv
// Shared definitions for the parking gate controller: gate FSM state
// encoding and the default filter/hold timing constants.
package parking_gate_ctrl_pkg;

   // Default number of consecutive equal synchronized samples before the
   // filtered sensor value is allowed to change.
   localparam int DEFAULT_DEBOUNCE = 4;

   // Default number of cycles a gate stays up after the car has cleared.
   localparam int DEFAULT_HOLD = 8;

   // Gate lifecycle: waiting, barrier up with car present, one-cycle
   // passage acknowledge, barrier still up while the hold timer runs.
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_OPEN = 2'd1,
      ST_PASS = 2'd2,
      ST_HOLD = 2'd3
   } gate_state_e;

endpackage : parking_gate_ctrl_pkg

// File: rtl/parking_gate_ctrl_gate_fsm.sv
// One lane of the parking gate: raw sensor synchronizer, debounce filter,
// gate state machine and saturating hold timer. Used for both lanes.
module gate_fsm
   import parking_gate_ctrl_pkg::*;
#(
   parameter int DEBOUNCE = DEFAULT_DEBOUNCE,
   parameter int HOLD     = DEFAULT_HOLD
) (
   input  logic clk,
   input  logic reset,
   input  logic sensor,
   input  logic permit,
   output logic gate_open,
   output logic pass,
   output logic idle,
   output logic filtered
);

   localparam int DB_W   = $clog2(DEBOUNCE) + 1;
   localparam int HOLD_W = $clog2(HOLD + 1);

   logic              sync1;
   logic              sync2;
   logic [DB_W-1:0]   db_cnt;
   logic [HOLD_W-1:0] hold_cnt;
   gate_state_e       state;

   assign idle = (state == ST_IDLE);

   // Two-flop synchronizer bringing the asynchronous sensor into clk.
   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples the pre-edge value of its neighbours, giving a true pipeline.
   always_ff @(posedge clk) begin
      if (reset) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
      end else begin
         sync1 <= sensor;
         sync2 <= sync1;
      end
   end

   // Debounce: flip the filtered value only after DEBOUNCE consecutive
   // synchronized samples disagree with it; any agreeing sample restarts.
   always_ff @(posedge clk) begin
      if (reset) begin
         filtered <= 1'b0;
         db_cnt   <= '0;
      end else if (sync2 == filtered) begin
         db_cnt <= '0;
      end else if (db_cnt == DB_W'(DEBOUNCE - 1)) begin
         filtered <= sync2;
         db_cnt   <= '0;
      end else begin
         db_cnt <= db_cnt + DB_W'(1);
      end
   end

   // Gate state machine with registered gate_open / pass outputs and the
   // hold timer; permit is only consulted when deciding to raise the gate.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= ST_IDLE;
         gate_open <= 1'b0;
         pass      <= 1'b0;
         hold_cnt  <= '0;
      end else begin
         pass <= 1'b0;
         unique case (state)
            ST_IDLE: begin
               if (filtered && permit) begin
                  state     <= ST_OPEN;
                  gate_open <= 1'b1;
               end
            end
            ST_OPEN: begin
               if (!filtered) begin
                  state <= ST_PASS;
                  pass  <= 1'b1;
               end
            end
            ST_PASS: begin
               state    <= ST_HOLD;
               hold_cnt <= '0;
            end
            ST_HOLD: begin
               if (filtered) begin
                  // A following car keeps the barrier up only if still allowed.
                  if (permit) begin
                     state <= ST_OPEN;
                  end else begin
                     state     <= ST_IDLE;
                     gate_open <= 1'b0;
                  end
               end else if (hold_cnt == HOLD_W'(HOLD - 1)) begin
                  state     <= ST_IDLE;
                  gate_open <= 1'b0;
               end else if (hold_cnt != HOLD_W'(HOLD)) begin
                  hold_cnt <= hold_cnt + HOLD_W'(1);
               end
            end
            default: begin
               state     <= ST_IDLE;
               gate_open <= 1'b0;
            end
         endcase
      end
   end

endmodule : gate_fsm

// File: rtl/parking_gate_ctrl.sv
// Parking gate controller top: two lane FSMs, occupancy permits, car
// in/out pulse arbitration, full rejection and exit fault reporting.
module parking_gate_ctrl
   import parking_gate_ctrl_pkg::*;
#(
   parameter int DEBOUNCE = DEFAULT_DEBOUNCE,
   parameter int HOLD     = DEFAULT_HOLD
) (
   input  logic clk,
   input  logic reset,
   input  logic entry_sensor,
   input  logic exit_sensor,
   input  logic full,
   input  logic empty,
   output logic car_in,
   output logic car_out,
   output logic entry_gate_open,
   output logic exit_gate_open,
   output logic full_reject,
   output logic exit_fault
);

   logic entry_permit;
   logic exit_permit;
   logic entry_pass;
   logic exit_pass;
   logic entry_idle;
   logic exit_idle;
   logic entry_filtered;
   logic exit_filtered;
   logic out_pending;

   assign entry_permit = ~full;
   assign exit_permit  = ~empty;

   gate_fsm #(
      .DEBOUNCE (DEBOUNCE),
      .HOLD     (HOLD)
   ) u_entry (
      .clk       (clk),
      .reset     (reset),
      .sensor    (entry_sensor),
      .permit    (entry_permit),
      .gate_open (entry_gate_open),
      .pass      (entry_pass),
      .idle      (entry_idle),
      .filtered  (entry_filtered)
   );

   gate_fsm #(
      .DEBOUNCE (DEBOUNCE),
      .HOLD     (HOLD)
   ) u_exit (
      .clk       (clk),
      .reset     (reset),
      .sensor    (exit_sensor),
      .permit    (exit_permit),
      .gate_open (exit_gate_open),
      .pass      (exit_pass),
      .idle      (exit_idle),
      .filtered  (exit_filtered)
   );

   // A car waiting at a closed entry gate because the lot is full.
   assign full_reject = entry_idle & entry_filtered & full;

   // Pulse arbitration: car_in wins a collision, car_out is deferred one
   // cycle through out_pending so the counter never sees both at once.
   always_ff @(posedge clk) begin
      if (reset) begin
         car_in      <= 1'b0;
         car_out     <= 1'b0;
         out_pending <= 1'b0;
      end else begin
         car_in <= entry_pass;
         if (entry_pass) begin
            car_out     <= 1'b0;
            out_pending <= exit_pass | out_pending;
         end else begin
            car_out     <= exit_pass | out_pending;
            out_pending <= 1'b0;
         end
      end
   end

   // Sticky flag: a car presented at the exit while the lot reads empty.
   always_ff @(posedge clk) begin
      if (reset) begin
         exit_fault <= 1'b0;
      end else if (exit_idle && exit_filtered && empty) begin
         exit_fault <= 1'b1;
      end
   end

endmodule : parking_gate_ctrl

// File: tb/tb_parking_gate_ctrl.sv
// Self-checking bench for parking_gate_ctrl: directed scenarios with fixed
// expected timings, then randomized traffic against a behavioural model.
module tb_parking_gate_ctrl;

   localparam int D = 4;
   localparam int H = 8;
   localparam int P_IDLE = 0;
   localparam int P_OPEN = 1;
   localparam int P_PASS = 2;
   localparam int P_HOLD = 3;

   logic clk = 1'b0;
   logic reset;
   logic entry_sensor;
   logic exit_sensor;
   logic full;
   logic empty;
   logic car_in;
   logic car_out;
   logic entry_gate_open;
   logic exit_gate_open;
   logic full_reject;
   logic exit_fault;

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;

   // Reference model state, lane 0 = entry, lane 1 = exit.
   int          ph[2];
   int          hold_end[2];
   bit          s1[2];
   bit          s2[2];
   bit          flt[2];
   logic [31:0] hist[2];
   int          owed;
   bit          e_in;
   bit          e_out;
   bit          e_fault;

   parking_gate_ctrl #(
      .DEBOUNCE (D),
      .HOLD     (H)
   ) dut (
      .clk             (clk),
      .reset           (reset),
      .entry_sensor    (entry_sensor),
      .exit_sensor     (exit_sensor),
      .full            (full),
      .empty           (empty),
      .car_in          (car_in),
      .car_out         (car_out),
      .entry_gate_open (entry_gate_open),
      .exit_gate_open  (exit_gate_open),
      .full_reject     (full_reject),
      .exit_fault      (exit_fault)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, act, exp, cyc);
      end
   endtask

   // Advance the model by one rising edge using the currently driven inputs.
   task automatic model_edge();
      bit          raw[2];
      bit          prm[2];
      bit          was_pass[2];
      bit          f;
      logic [31:0] mask;
      raw[0] = entry_sensor;
      raw[1] = exit_sensor;
      prm[0] = !full;
      prm[1] = !empty;
      mask   = (32'd1 << D) - 32'd1;
      if (reset) begin
         for (int l = 0; l < 2; l++) begin
            ph[l] = P_IDLE; s1[l] = 0; s2[l] = 0; flt[l] = 0; hist[l] = '0;
         end
         owed = 0; e_in = 0; e_out = 0; e_fault = 0;
      end else begin
         if (ph[1] == P_IDLE && flt[1] && empty) e_fault = 1;
         for (int l = 0; l < 2; l++) begin
            f = flt[l];
            was_pass[l] = (ph[l] == P_PASS);
            case (ph[l])
               P_IDLE: if (f && prm[l]) ph[l] = P_OPEN;
               P_OPEN: if (!f) ph[l] = P_PASS;
               P_PASS: begin ph[l] = P_HOLD; hold_end[l] = cyc + H; end
               default: begin
                  if (f) ph[l] = prm[l] ? P_OPEN : P_IDLE;
                  else if (cyc == hold_end[l]) ph[l] = P_IDLE;
               end
            endcase
            // Filter flips once the last D samples all disagree with it.
            hist[l] = {hist[l][30:0], s2[l]};
            if (f ? ((hist[l] & mask) == 32'd0) : ((hist[l] & mask) == mask))
               flt[l] = !f;
            s2[l] = s1[l];
            s1[l] = raw[l];
         end
         owed  = owed + int'(was_pass[1]);
         e_in  = was_pass[0];
         e_out = !e_in && (owed > 0);
         if (e_out) owed--;
      end
      cyc++;
   endtask

   task automatic compare_all();
      check("entry_gate_open", entry_gate_open, ph[0] != P_IDLE);
      check("exit_gate_open", exit_gate_open, ph[1] != P_IDLE);
      check("car_in", car_in, e_in);
      check("car_out", car_out, e_out);
      check("full_reject", full_reject, (ph[0] == P_IDLE) && flt[0] && full);
      check("exit_fault", exit_fault, e_fault);
      check("no_overlap", car_in & car_out, 0);
   endtask

   task automatic step();
      model_edge();
      @(posedge clk);
      @(negedge clk);
      compare_all();
   endtask

   task automatic do_reset();
      reset = 1'b1;
      step();
      reset = 1'b0;
   endtask

   int rise, close_e, in_e, out_e, n_in, n_out, n_open;

   initial begin
      reset = 1'b1; entry_sensor = 0; exit_sensor = 0; full = 0; empty = 0;
      @(negedge clk);
      do_reset();
      check("reset_outputs", {car_in, car_out, entry_gate_open, exit_gate_open,
                              full_reject, exit_fault}, 0);

      // Single entry car: open at edge 6, car_in at 17, close at 25.
      entry_sensor = 1; rise = -1; close_e = -1; in_e = -1; n_in = 0;
      for (int k = 0; k < 40; k++) begin
         if (k == 10) entry_sensor = 0;
         step();
         if (rise < 0 && entry_gate_open) rise = k;
         if (car_in) begin n_in++; if (in_e < 0) in_e = k; end
         if (rise >= 0 && close_e < 0 && !entry_gate_open) close_e = k;
      end
      check("entry_open_edge", rise, 6);
      check("car_in_edge", in_e, 17);
      check("entry_close_edge", close_e, 25);
      check("car_in_count", n_in, 1);

      // Full lot: gate stays down, reject raised, no car counted.
      do_reset();
      full = 1; entry_sensor = 1; n_open = 0; n_in = 0;
      for (int k = 0; k < 20; k++) begin
         step();
         n_open += int'(entry_gate_open);
         n_in   += int'(car_in);
      end
      check("full_no_open", n_open, 0);
      check("full_reject_level", full_reject, 1);
      check("full_no_car_in", n_in, 0);
      entry_sensor = 0; full = 0;

      // Collision: both lanes pass together, car_out one cycle after car_in.
      do_reset();
      entry_sensor = 1; exit_sensor = 1; in_e = -1; out_e = -1; n_in = 0; n_out = 0;
      for (int k = 0; k < 40; k++) begin
         if (k == 10) begin entry_sensor = 0; exit_sensor = 0; end
         step();
         if (car_in)  begin n_in++;  if (in_e < 0)  in_e = k;  end
         if (car_out) begin n_out++; if (out_e < 0) out_e = k; end
      end
      check("collision_in_edge", in_e, 17);
      check("collision_out_edge", out_e, 18);
      check("collision_counts", {n_in[15:0], n_out[15:0]}, {16'd1, 16'd1});

      // Reset during HOLD with a deferred car_out outstanding.
      do_reset();
      entry_sensor = 1; exit_sensor = 1; n_out = 0;
      for (int k = 0; k < 30; k++) begin
         if (k == 10) begin entry_sensor = 0; exit_sensor = 0; end
         if (k == 18) reset = 1;
         step();
         if (k == 18) begin
            reset = 0;
            check("reset_hold_gates", {entry_gate_open, exit_gate_open}, 0);
         end
         if (k >= 18) n_out += int'(car_out) + int'(car_in);
      end
      check("reset_drops_pulse", n_out, 0);

      // Bouncing sensor never settles long enough to open the gate.
      do_reset();
      n_open = 0; n_in = 0;
      for (int k = 0; k < 20; k++) begin
         entry_sensor = ((k / 2) % 2) == 0;
         step();
         n_open += int'(entry_gate_open);
         n_in   += int'(car_in);
      end
      entry_sensor = 0;
      for (int k = 0; k < 10; k++) step();
      check("bounce_no_open", n_open, 0);
      check("bounce_no_pulse", n_in, 0);

      // Exit while empty: gate stays down, fault latches until reset.
      do_reset();
      empty = 1; exit_sensor = 1; n_open = 0;
      for (int k = 0; k < 15; k++) begin
         step();
         n_open += int'(exit_gate_open);
      end
      check("empty_no_open", n_open, 0);
      check("exit_fault_set", exit_fault, 1);
      exit_sensor = 0; empty = 0;
      for (int k = 0; k < 10; k++) step();
      check("exit_fault_sticky", exit_fault, 1);
      do_reset();
      check("exit_fault_cleared", exit_fault, 0);

      // Randomized traffic against the model.
      for (int k = 0; k < 3000; k++) begin
         if ($urandom_range(0, 9) == 0)   entry_sensor = !entry_sensor;
         if ($urandom_range(0, 9) == 0)   exit_sensor  = !exit_sensor;
         if ($urandom_range(0, 39) == 0)  full  = !full;
         if ($urandom_range(0, 39) == 0)  empty = !empty;
         reset = ($urandom_range(0, 499) == 0);
         step();
      end
      reset = 0;

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule : tb_parking_gate_ctrl
